// File: rtl/dmem_bank_if.sv
// rtl/dmem_bank_if.sv - request/response bus of the data memory bank
interface dmem_bank_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_byteen, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_byteen, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - single-port word memory bank with byte lanes and fixed access latency
// DMEM_CLEAR_EN: zero every word after reset before accepting requests.
module dmem_bank #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          WAIT_CYC  = 0
) (
  input logic        clk,
  input logic        reset,
  dmem_bank_if.slave bus
);

  localparam int          AW           = $clog2(DEPTH);
  localparam logic [31:0] LP_SPAN      = 32'(4 * DEPTH);
  localparam logic [3:0]  LP_WAIT_LOAD = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

`ifdef DMEM_CLEAR_EN
  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_RESP} state_t;
  localparam state_t LP_RST_STATE = ST_CLEAR;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  localparam state_t LP_RST_STATE = ST_IDLE;
`endif

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_byteen;
  logic [3:0]  r_wait_cnt;
`ifdef DMEM_CLEAR_EN
  logic [AW-1:0] r_clr_cnt;
`endif

  logic          w_ready;
  logic          w_rsp;
  logic          w_hs;
  logic [31:0]   w_offset;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_old;

  // Offset wraps below BASE_ADDR, so one unsigned compare covers both bounds.
  assign w_offset   = r_addr - BASE_ADDR;
  assign w_in_range = (w_offset < LP_SPAN);
  assign w_idx      = w_offset[AW+1:2];
  assign w_old      = r_mem[w_idx];
  assign w_hs       = bus.req_valid && w_ready;

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_rsp        = 1'b0;
    case (r_state)
`ifdef DMEM_CLEAR_EN
      ST_CLEAR: begin
        if (r_clr_cnt == {AW{1'b1}}) w_state_next = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) w_state_next = (WAIT_CYC > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        if (r_wait_cnt == 4'd0) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        w_rsp        = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = LP_RST_STATE;
    endcase
  end

  // Outputs are gated by reset so they drop the instant reset rises.
  assign bus.req_ready = w_ready & ~reset;
  assign bus.rsp_valid = w_rsp & ~reset;
  assign bus.rsp_rdata = (w_rsp && !reset && w_in_range) ? w_old : 32'h0;
  assign bus.rsp_err   = w_rsp & ~reset & ~w_in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LP_RST_STATE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_byteen <= 4'h0;
    end else if (w_hs) begin
      r_addr   <= bus.req_addr;
      r_wdata  <= bus.req_wdata;
      r_byteen <= bus.req_byteen;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= 4'd0;
    end else if (w_hs) begin
      r_wait_cnt <= LP_WAIT_LOAD;
    end else if (r_state == ST_WAIT && r_wait_cnt != 4'd0) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

`ifdef DMEM_CLEAR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_clr_cnt <= '0;
    else if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
  end
`endif

  // Storage has no reset; a write commits only on the edge leaving RESP.
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_cnt] <= 32'h0;
    end else
`endif
    if (r_state == ST_RESP && (|r_byteen) && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (r_byteen[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_bank.sv
// tb/tb_dmem_bank.sv - scoreboard bench for dmem_bank over three parameter sets
module tb_dmem_bank;

`ifdef DMEM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        chk;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  dmem_bank_if if_a ();
  dmem_bank_if if_b ();
  dmem_bank_if if_c ();

  dmem_bank #(.DEPTH(16), .BASE_ADDR(32'h0000_0000), .WAIT_CYC(0))
    u_a (.clk(clk), .reset(rst_a), .bus(if_a));
  dmem_bank #(.DEPTH(16), .BASE_ADDR(32'h0000_0000), .WAIT_CYC(3))
    u_b (.clk(clk), .reset(rst_b), .bus(if_b));
  dmem_bank #(.DEPTH(32), .BASE_ADDR(32'h0000_1000), .WAIT_CYC(1))
    u_c (.clk(clk), .reset(rst_c), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, int d, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  function automatic int wait_of(int d);
    case (d)
      0:       return 0;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic logic get_ready(int d);
    case (d)
      0:       return if_a.req_ready;
      1:       return if_b.req_ready;
      default: return if_c.req_ready;
    endcase
  endfunction

  function automatic logic get_rspv(int d);
    case (d)
      0:       return if_a.rsp_valid;
      1:       return if_b.rsp_valid;
      default: return if_c.rsp_valid;
    endcase
  endfunction

  function automatic int qsize(int d);
    case (d)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic qpush(int d, exp_t x);
    case (d)
      0:       q_a.push_back(x);
      1:       q_b.push_back(x);
      default: q_c.push_back(x);
    endcase
  endtask

  task automatic qpop(int d, output exp_t x);
    case (d)
      0:       x = q_a.pop_front();
      1:       x = q_b.pop_front();
      default: x = q_c.pop_front();
    endcase
  endtask

  task automatic drive(int d, logic v, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
    case (d)
      0: begin if_a.req_valid = v; if_a.req_addr = a; if_a.req_byteen = be; if_a.req_wdata = wd; end
      1: begin if_b.req_valid = v; if_b.req_addr = a; if_b.req_byteen = be; if_b.req_wdata = wd; end
      default: begin if_c.req_valid = v; if_c.req_addr = a; if_c.req_byteen = be; if_c.req_wdata = wd; end
    endcase
  endtask

  task automatic mon(int d, logic v, logic [31:0] rd, logic e);
    exp_t x;
    if (v) begin
      if (qsize(d) == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1, expected 0 (t=%0t)", d, $time);
      end else begin
        qpop(d, x);
        if (x.chk) check("rsp_rdata", d, rd, x.rdata);
        check("rsp_err", d, {31'h0, e}, {31'h0, x.err});
        check("latency_cycle", d, 32'(cyc), 32'(x.cyc));
      end
    end else begin
      check("idle_rsp_zero", d, {rd[31:1], rd[0] | e}, 32'h0);
    end
  endtask

  always @(negedge clk) mon(0, if_a.rsp_valid, if_a.rsp_rdata, if_a.rsp_err);
  always @(negedge clk) mon(1, if_b.rsp_valid, if_b.rsp_rdata, if_b.rsp_err);
  always @(negedge clk) mon(2, if_c.rsp_valid, if_c.rsp_rdata, if_c.rsp_err);

  // Handshake, then scramble the (now ignored) request inputs with valid low.
  task automatic send(int d, logic [31:0] a, logic [3:0] be, logic [31:0] wd,
                      logic push, logic [31:0] exp_rd, logic chk, logic exp_err);
    exp_t x;
    int   n = 0;
    @(negedge clk);
    drive(d, 1'b1, a, be, wd);
    while (!get_ready(d) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!get_ready(d)) begin
      n_vec++;
      n_err++;
      $display("FAIL handshake_timeout dut%0d: got req_ready=0, expected 1", d);
      drive(d, 1'b0, 32'h0, 4'h0, 32'h0);
      return;
    end
    if (push) begin
      x.rdata = exp_rd;
      x.chk   = chk;
      x.err   = exp_err;
      x.cyc   = cyc + wait_of(d) + 1;
      qpush(d, x);
    end
    @(negedge clk);
    drive(d, 1'b0, 32'hFFFF_FFF0, 4'hF, 32'hDEAD_0000);
  endtask

  task automatic access(int d, logic [31:0] a, logic [3:0] be, logic [31:0] wd,
                       logic [31:0] exp_rd, logic chk, logic exp_err);
    int n = 0;
    send(d, a, be, wd, 1'b1, exp_rd, chk, exp_err);
    while (qsize(d) != 0 && n < 100) begin
      check("ready_low_busy", d, {31'h0, get_ready(d)}, 32'h0);
      @(negedge clk);
      n++;
    end
    if (qsize(d) != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL rsp_timeout dut%0d: got no rsp_valid, expected one", d);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(2, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_ready", d, {31'h0, get_ready(d)}, 32'h0);
      check("reset_rspv", d, {31'h0, get_rspv(d)}, 32'h0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    #1;
    if (CLR) begin
      for (int i = 0; i < 16; i++) begin
        check("clear_ready_low", 0, {31'h0, get_ready(0)}, 32'h0);
        @(negedge clk);
      end
      check("clear_ready_high", 0, {31'h0, get_ready(0)}, 32'h1);
      for (int i = 0; i < 16; i++) access(0, 32'(4 * i), 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    end else begin
      for (int d = 0; d < 3; d++) check("ready_after_release", d, {31'h0, get_ready(d)}, 32'h1);
    end

    // WAIT_CYC=0 bank
    access(0, 32'h0,  4'hF, 32'h0F0F_0F0F, 32'h0, CLR, 1'b0);
    access(0, 32'h3C, 4'hF, 32'h3C3C_3C3C, 32'h0, CLR, 1'b0);
    access(0, 32'h8,  4'hF, 32'h0000_0000, 32'h0, CLR, 1'b0);
    access(0, 32'h8,  4'hF, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0);
    access(0, 32'h8,  4'h0, 32'h0,         32'h1234_5678, 1'b1, 1'b0);
    access(0, 32'h8,  4'b0010, 32'hAABB_CCDD, 32'h1234_5678, 1'b1, 1'b0);
    access(0, 32'h8,  4'h0, 32'h0,         32'h1234_CC78, 1'b1, 1'b0);
    access(0, 32'h9,  4'b1001, 32'h1122_3344, 32'h1234_CC78, 1'b1, 1'b0);
    access(0, 32'hB,  4'h0, 32'h0,         32'h1134_CC44, 1'b1, 1'b0);
    access(0, 32'h40, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    access(0, 32'h0,  4'h0, 32'h0,         32'h0F0F_0F0F, 1'b1, 1'b0);
    access(0, 32'h3C, 4'h0, 32'h0,         32'h3C3C_3C3C, 1'b1, 1'b0);
    access(0, 32'h8,  4'h0, 32'h0,         32'h1134_CC44, 1'b1, 1'b0);
    access(0, 32'hFFFF_FFFC, 4'h0, 32'h0,  32'h0, 1'b1, 1'b1);

    // WAIT_CYC=3 bank, including reset during WAIT
    access(1, 32'h4, 4'hF, 32'hCAFE_F00D, 32'h0, CLR, 1'b0);
    access(1, 32'hC, 4'hF, 32'h0BAD_BEEF, 32'h0, CLR, 1'b0);
    access(1, 32'h4, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0);
    access(1, 32'h4, 4'b1100, 32'h1111_2222, 32'hCAFE_F00D, 1'b1, 1'b0);
    access(1, 32'h4, 4'h0, 32'h0,         32'h1111_F00D, 1'b1, 1'b0);
    send(1, 32'hC, 4'hF, 32'hDEAD_DEAD, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("abort_ready", 1, {31'h0, get_ready(1)}, 32'h0);
      check("abort_rspv", 1, {31'h0, get_rspv(1)}, 32'h0);
      @(negedge clk);
    end
    rst_b = 1'b0;
    access(1, 32'hC, 4'h0, 32'h0, CLR ? 32'h0 : 32'h0BAD_BEEF, 1'b1, 1'b0);
    access(1, 32'h4, 4'h0, 32'h0, CLR ? 32'h0 : 32'h1111_F00D, 1'b1, 1'b0);

    // WAIT_CYC=1 bank at a non-zero base
    access(2, 32'h1000, 4'hF, 32'hA5A5_0001, 32'h0, CLR, 1'b0);
    access(2, 32'h107C, 4'hF, 32'h5A5A_007C, 32'h0, CLR, 1'b0);
    access(2, 32'h1003, 4'h0, 32'h0, 32'hA5A5_0001, 1'b1, 1'b0);
    access(2, 32'h107C, 4'h0, 32'h0, 32'h5A5A_007C, 1'b1, 1'b0);
    access(2, 32'h0FFC, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    access(2, 32'h1080, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    access(2, 32'h1000, 4'h0, 32'h0, 32'hA5A5_0001, 1'b1, 1'b0);
    access(2, 32'h0000, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);

    repeat (6) @(negedge clk);
    for (int d = 0; d < 3; d++) check("queue_drained", d, 32'(qsize(d)), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_bank.md
DMEM_BANK -- requirements
Module: dmem_bank

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, number of 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (DEPTH*4-aligned).
REQ-003 SHALL have parameter WAIT_CYC, default 0, extra wait cycles per access (0..15).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-008 SHALL have port req_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port req_byteen  input  4  byte-lane write enables; 4'b0000 means read.
REQ-010 SHALL have port req_wdata  input  32  write data, lane i = bits [8i+7:8i].
REQ-011 SHALL have port rsp_valid  output  1  one-cycle pulse, access complete.
REQ-012 SHALL have port rsp_rdata  output  32  word contents before the access (read or write), valid with rsp_valid.
REQ-013 SHALL have port rsp_err  output  1  address out of range, valid with rsp_valid.

Function
REQ-014 SHALL implement states CLEAR, IDLE, WAIT, RESP.
REQ-015 SHALL assert req_ready only in IDLE; the handshake is req_valid && req_ready.
REQ-016 SHALL, on handshake, capture addr/byteen/wdata and go to WAIT if WAIT_CYC>0, else RESP.
REQ-017 SHALL stay in WAIT for exactly WAIT_CYC cycles via a down-counter, then go to RESP.
REQ-018 SHALL in RESP assert rsp_valid for one cycle and return to IDLE next cycle; total latency handshake-to-rsp_valid = WAIT_CYC+1 cycles.
REQ-019 SHALL compute word index = (req_addr - BASE_ADDR) >> 2; in range iff req_addr in [BASE_ADDR, BASE_ADDR+4*DEPTH).
REQ-020 SHALL on in-range write update only lanes with byteen set, other lanes unchanged, committed on the RESP cycle edge.
REQ-021 SHALL on out-of-range access write nothing, drive rsp_rdata=0, rsp_err=1.
REQ-022 SHALL drive rsp_rdata=0 and rsp_err=0 whenever rsp_valid is low.
REQ-023 SHALL ignore req_valid changes while not in IDLE (captured request is held).
REQ-024 SHALL make back-to-back accesses see prior writes (write at RESP visible to next handshake's read).

Reset
REQ-025 SHALL on reset immediately force req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counters=0.
REQ-026 SHALL leave reset into CLEAR (macro defined) or IDLE (macro undefined).
REQ-027 SHALL abort any in-flight access on reset mid-operation: no response, pending write discarded.

Configuration
REQ-028 SHALL, with DMEM_CLEAR_EN defined, in CLEAR write 0 to one word per cycle, index 0..DEPTH-1, then enter IDLE; req_ready low for exactly DEPTH cycles after reset release.
REQ-029 SHALL, without DMEM_CLEAR_EN, omit CLEAR and its counter; memory contents undefined after reset, req_ready high first cycle after reset release.

Verification
REQ-030 SHALL test: DMEM_CLEAR_EN, DEPTH=16, reset release -> req_ready low 16 cycles, then reads of all words return 0.
REQ-031 SHALL test: WAIT_CYC=0, write addr 0x8 byteen 4'b1111 data 0x12345678, then read 0x8 -> rsp_valid 1 cycle after each handshake, read rdata 0x12345678.
REQ-032 SHALL test: after REQ-031, write 0x8 byteen 4'b0010 data 0xAABBCCDD, read 0x8 -> 0x1234CC78.
REQ-033 SHALL test: WAIT_CYC=3, read 0x4 -> rsp_valid exactly 4 cycles after handshake, req_ready low meanwhile.
REQ-034 SHALL test: DEPTH=16, BASE_ADDR=0, write 0x40 data 0xFFFFFFFF -> rsp_err=1, rdata=0, no word modified.
REQ-035 SHALL test: reset asserted during WAIT of a write to 0xC -> no rsp_valid, word 0xC unchanged after re-init.
